fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide ports (name  direction  width  meaning), clock and reset first.
REQ-002 SHALL have one clock, Clk; reset is synchronous and active-high, named Reset.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high; forces reset state at the next rising Clk edge.
REQ-005 Start  input  1  level request to begin program execution from address 0.
REQ-006 BranchEn  input  1  from control decoder; current instruction is a branch.
REQ-007 BranchCond  input  1  from ALU flags; branch condition true.
REQ-008 Target  input  10  absolute branch target address (from LUT).
REQ-009 Ack  input  1  from control decoder; current instruction is the halt word (9'h1FF).
REQ-010 ProgCtr  output  10  instruction ROM address of the current instruction.
REQ-011 Running  output  1  high while in RUN.
REQ-012 Done  output  1  high while in DONE.
REQ-013 InstrCount  output  16  instructions executed in the current or most recent run.

Function
REQ-014 SHALL implement a registered FSM with states IDLE, RUN and DONE.
REQ-015 IDLE: ProgCtr holds; Running=0; Done=0; with Start=1, next state is RUN, ProgCtr<=0 and InstrCount<=0.
REQ-016 RUN, Ack=1: next state is DONE; ProgCtr holds (stays on the halt address); InstrCount increments.
REQ-017 RUN, Ack=0, BranchEn=1, BranchCond=1: ProgCtr<=Target; InstrCount increments.
REQ-018 RUN, Ack=0, other cases (including BranchEn=1 with BranchCond=0): ProgCtr<=ProgCtr+1 mod 1024; InstrCount increments.
REQ-019 Ack has priority over a branch in the same cycle; the branch is ignored.
REQ-020 ProgCtr SHALL wrap from 10'h3FF to 10'h000 on sequential increment, with no flag or stall.
REQ-021 InstrCount SHALL saturate at 16'hFFFF and never wrap.
REQ-022 Start SHALL be ignored in RUN; a run ends only by Ack or Reset.
REQ-023 DONE: Done=1; ProgCtr and InstrCount hold; Start=0 moves to IDLE; Start=1 keeps DONE, so a level-held Start cannot retrigger.
REQ-024 BranchEn, BranchCond, Target and Ack SHALL be ignored outside RUN.
REQ-025 Running and Done SHALL be decoded directly from the state register (registered, glitch-free); they are never both high.
REQ-026 Latency: a branch decision in cycle N is visible on ProgCtr in cycle N+1; a Start sampled in IDLE gives ProgCtr=0 and Running=1 in the next cycle.

Reset
REQ-027 With Reset=1 at a rising edge: state<=IDLE, ProgCtr<=0, InstrCount<=0, Running=0, Done=0; all other inputs are ignored.
REQ-028 Reset SHALL take effect in any state, including mid-RUN, with no DONE passage.
REQ-029 After reset is released, RUN requires a fresh Start=1 sample in IDLE.

Verification
REQ-030 Reset, then Start=1 for 1 cycle, no branch/Ack, 5 cycles -> ProgCtr 0,1,2,3,4; Running=1; InstrCount=4 after the 4th increment.
REQ-031 In RUN at ProgCtr=7, BranchEn=1, BranchCond=1, Target=10'h155 -> next ProgCtr=10'h155; with BranchCond=0 -> next ProgCtr=8.
REQ-032 At ProgCtr=10'h3FF, no branch -> next ProgCtr=10'h000, state stays RUN.
REQ-033 At ProgCtr=12, Ack=1 together with a taken branch to 10'h020 -> state DONE, ProgCtr stays 12, Done=1, Running=0; Start held 1 -> DONE persists; Start=0 -> IDLE; Start=1 -> RUN at ProgCtr=0, InstrCount=0.
REQ-034 Reset=1 mid-RUN at ProgCtr=10'h0A3 -> next cycle IDLE, ProgCtr=0, InstrCount=0, Running=0, Done=0.
REQ-035 Force InstrCount to 16'hFFFE and run 3 more cycles -> InstrCount reads 16'hFFFF and stays there.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: program counter sequencer for a small instruction ROM.
// Walks IDLE -> RUN -> DONE, follows taken branches, stops on the halt
// word, and keeps a saturating count of the instructions executed.
module fetch_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        BranchEn,
  input  logic        BranchCond,
  input  logic [9:0]  Target,
  input  logic        Ack,
  output logic [9:0]  ProgCtr,
  output logic        Running,
  output logic        Done,
  output logic [15:0] InstrCount
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  pc_q, pc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cnt_inc;

  // Saturating increment: the count sticks at all-ones instead of wrapping.
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  // Next-state, next-PC and next-count selection.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_RUN;
          pc_d    = 10'd0;
          cnt_d   = 16'd0;
        end
      end
      S_RUN: begin
        // The halt word wins over a branch in the same cycle; PC parks on it.
        cnt_d = cnt_inc;
        if (Ack) begin
          state_d = S_DONE;
        end else if (BranchEn && BranchCond) begin
          pc_d = Target;
        end else begin
          pc_d = pc_q + 10'd1;  // wraps 3FF -> 000 naturally
        end
      end
      S_DONE: begin
        // Leave only once Start drops, so a held Start cannot restart the run.
        if (!Start) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, PC and count registers with synchronous active-high reset.
  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= 10'd0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status flags decode straight from the state register, so they are glitch-free.
  assign Running    = (state_q == S_RUN);
  assign Done       = (state_q == S_DONE);
  assign ProgCtr    = pc_q;
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with literal expectations, plus a
// behavioural model compared against the DUT on every cycle after reset.
module tb_fetch_unit;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic        BranchEn;
  logic        BranchCond;
  logic [9:0]  Target;
  logic        Ack;
  logic [9:0]  ProgCtr;
  logic        Running;
  logic        Done;
  logic [15:0] InstrCount;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_unit dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .BranchEn   (BranchEn),
    .BranchCond (BranchCond),
    .Target     (Target),
    .Ack        (Ack),
    .ProgCtr    (ProgCtr),
    .Running    (Running),
    .Done       (Done),
    .InstrCount (InstrCount)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  // ---------------- behavioural model ----------------
  // The program is either waiting, executing, or finished; the model keeps
  // that as two plain flags plus an integer address and count.
  bit m_valid   = 0;
  bit m_running = 0;
  bit m_done    = 0;
  int m_pc      = 0;
  int m_cnt     = 0;

  always @(posedge Clk) begin
    if (Reset) begin
      m_valid = 1; m_running = 0; m_done = 0; m_pc = 0; m_cnt = 0;
    end else if (m_valid) begin
      if (m_running) begin
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (Ack) begin
          m_running = 0; m_done = 1;
        end else if (BranchEn && BranchCond) begin
          m_pc = int'(Target);
        end else begin
          m_pc = (m_pc + 1) % 1024;
        end
      end else if (m_done) begin
        if (!Start) m_done = 0;
      end else if (Start) begin
        m_running = 1; m_pc = 0; m_cnt = 0;
      end
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge Clk) begin
    if (m_valid) begin
      check("model_pc",      32'(ProgCtr),    32'(m_pc));
      check("model_cnt",     32'(InstrCount), 32'(m_cnt));
      check("model_running", 32'(Running),    32'(m_running));
      check("model_done",    32'(Done),       32'(m_done));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [9:0] pc, input logic run,
                            input logic dn, input logic [15:0] cnt);
    check({name, "_pc"},   32'(ProgCtr),    32'(pc));
    check({name, "_run"},  32'(Running),    32'(run));
    check({name, "_done"}, 32'(Done),       32'(dn));
    check({name, "_cnt"},  32'(InstrCount), 32'(cnt));
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; BranchEn = 1'b0; BranchCond = 1'b0;
    Target = 10'd0; Ack = 1'b0;
    tick();
    tick();
    expect_out("reset", 10'd0, 1'b0, 1'b0, 16'd0);
    Reset = 1'b0;
    tick();
    expect_out("idle_hold", 10'd0, 1'b0, 1'b0, 16'd0);

    // Start for one cycle, then straight-line execution.
    Start = 1'b1;
    tick();
    Start = 1'b0;
    expect_out("start", 10'd0, 1'b1, 1'b0, 16'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      expect_out("seq", 10'(i), 1'b1, 1'b0, 16'(i));
    end
    for (int i = 5; i <= 7; i++) tick();
    expect_out("at7", 10'd7, 1'b1, 1'b0, 16'd7);

    // Untaken branch falls through, then return to 7 and take one.
    BranchEn = 1'b1; BranchCond = 1'b0; Target = 10'h155;
    tick();
    expect_out("br_untaken", 10'd8, 1'b1, 1'b0, 16'd8);
    BranchCond = 1'b1; Target = 10'd7;
    tick();
    expect_out("br_back7", 10'd7, 1'b1, 1'b0, 16'd9);
    Target = 10'h155;
    tick();
    expect_out("br_taken", 10'h155, 1'b1, 1'b0, 16'd10);

    // Sequential wrap at the top of the address space.
    Target = 10'h3FF;
    tick();
    expect_out("to_3ff", 10'h3FF, 1'b1, 1'b0, 16'd11);
    BranchEn = 1'b0; BranchCond = 1'b0;
    tick();
    expect_out("wrap", 10'h000, 1'b1, 1'b0, 16'd12);

    // Start held during RUN must not restart the program.
    Start = 1'b1;
    tick();
    tick();
    expect_out("start_in_run", 10'd2, 1'b1, 1'b0, 16'd14);
    Start = 1'b0;

    // Halt coincident with a taken branch: halt wins.
    BranchEn = 1'b1; BranchCond = 1'b1; Target = 10'd12;
    tick();
    expect_out("to_12", 10'd12, 1'b1, 1'b0, 16'd15);
    Ack = 1'b1; Target = 10'h020;
    tick();
    expect_out("halt", 10'd12, 1'b0, 1'b1, 16'd16);
    Start = 1'b1;
    tick();
    expect_out("done_hold", 10'd12, 1'b0, 1'b1, 16'd16);
    Start = 1'b0;
    tick();
    expect_out("to_idle", 10'd12, 1'b0, 1'b0, 16'd16);
    tick();
    expect_out("idle_ignores", 10'd12, 1'b0, 1'b0, 16'd16);
    Start = 1'b1;
    tick();
    expect_out("restart", 10'd0, 1'b1, 1'b0, 16'd0);
    Start = 1'b0; Ack = 1'b0;

    // Reset mid-run, with other inputs active, then no auto-restart.
    Target = 10'h0A3;
    tick();
    expect_out("to_0a3", 10'h0A3, 1'b1, 1'b0, 16'd1);
    Reset = 1'b1; Start = 1'b1;
    tick();
    expect_out("mid_reset", 10'd0, 1'b0, 1'b0, 16'd0);
    Reset = 1'b0; Start = 1'b0; BranchEn = 1'b0; BranchCond = 1'b0;
    tick();
    expect_out("post_reset", 10'd0, 1'b0, 1'b0, 16'd0);

    // Long run to reach count saturation.
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 65534; i++) tick();
    expect_out("cnt_fffe", 10'h3FE, 1'b1, 1'b0, 16'hFFFE);
    tick();
    expect_out("cnt_sat1", 10'h3FF, 1'b1, 1'b0, 16'hFFFF);
    tick();
    expect_out("cnt_sat2", 10'h000, 1'b1, 1'b0, 16'hFFFF);
    tick();
    expect_out("cnt_sat3", 10'h001, 1'b1, 1'b0, 16'hFFFF);

    @(negedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
